sha256_stream: RTL



---
 rtl/sha256_stream.sv | 266 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/sha256_stream.sv
// Purpose : SHA-256 of a word-aligned message (0..MAX_WORDS words) read from a
//           single-port memory; the digest is written back as 8 words (H0 first).
// Latency : done low for 82*B+8 cycles, B = (N+18)/16 blocks (17 load, 64 rounds, 1 update per block).
// Backpr. : none; start is only sampled while idle and the memory answers in a fixed 1 cycle.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   start                 request, sampled only while done=1
//   message_addr          word address of message word 0
//   output_addr           word address where H0..H7 are written
//   message_words         message length N in words (start ignored if N > MAX_WORDS)
//   done                  high while idle
//   mem_clk/mem_we/mem_addr/mem_write_data/mem_read_data
//                         shared memory bus, read data returns one cycle after its address
//   cycle_count           only with SHA256_CYCLE_CNT_EN: busy cycles of the last hash
//
// Optional feature macro: SHA256_CYCLE_CNT_EN.
module sha256_stream #(
    parameter int MAX_WORDS = 1024,
    parameter int ADDR_W    = 16,
    parameter int LEN_W     = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] message_addr,
    input  logic [ADDR_W-1:0] output_addr,
    input  logic [LEN_W-1:0]  message_words,
    output logic              done,
    output logic              mem_clk,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_write_data,
    input  logic [31:0]       mem_read_data
`ifdef SHA256_CYCLE_CNT_EN
    ,
    output logic [31:0]       cycle_count
`endif
);

    // A padded word index g = {blk, k} never exceeds N+17, so one extra bit suffices.
    localparam int BLK_W = LEN_W - 3;
    localparam int G_W   = LEN_W + 1;
    localparam logic [G_W-1:0] MAX_L = G_W'(MAX_WORDS);

    localparam logic [31:0] K_TAB [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [31:0] IV_TAB [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_COMPUTE, S_UPDATE, S_WRITE} state_t;

    state_t            state, state_nxt;
    logic [6:0]        cnt, cnt_nxt;
    logic [BLK_W-1:0]  blk;
    logic [LEN_W-1:0]  n_q;
    logic [ADDR_W-1:0] msg_base, out_base;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdat_q;

    logic [31:0] w  [16];
    logic [31:0] hv [8];
    logic [31:0] a, b, c, d, e, f, g, h;

    logic           start_ok;
    logic [G_W-1:0] n_ext, g_fetch, g_cap;
    logic [3:0]     k_cap;
    logic           fetch_rd, last_blk;
    logic [63:0]    bitlen;
    logic [31:0]    cap_word, w_new, t1, t2;

    function automatic logic [31:0] bsig0(input logic [31:0] x);
        return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
    endfunction

    function automatic logic [31:0] bsig1(input logic [31:0] x);
        return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
    endfunction

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b0, x[31:3]};
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
    endfunction

    assign mem_clk  = clk;
    assign done     = (state == S_IDLE);
    assign start_ok = (state == S_IDLE) && start && ({1'b0, message_words} <= MAX_L);

    assign n_ext   = {1'b0, n_q};
    assign g_fetch = {blk, cnt[3:0]};
    // Capture in LOAD cycle k (1..16) is for word k-1; at cnt=16 this wraps to 15.
    assign k_cap   = cnt[3:0] - 4'd1;
    assign g_cap   = {blk, k_cap};
    assign bitlen  = {{(64-LEN_W-5){1'b0}}, n_q, 5'b0};

    // The block holding word N+2 (padding marker plus the two length words) is the last.
    assign last_blk = ({blk, 4'hF} >= (n_ext + G_W'(2)));
    assign fetch_rd = (state == S_LOAD) && !cnt[4] && (g_fetch < n_ext);

    always_comb begin
        cap_word = 32'h0;
        if (g_cap < n_ext)
            cap_word = mem_read_data;
        else if (g_cap == n_ext)
            cap_word = 32'h8000_0000;
        else if (last_blk && (k_cap == 4'd14))
            cap_word = bitlen[63:32];
        else if (last_blk && (k_cap == 4'd15))
            cap_word = bitlen[31:0];
    end

    // Bus outputs hold their last value whenever nothing is being read or written.
    always_comb begin
        mem_we         = 1'b0;
        mem_addr       = addr_q;
        mem_write_data = wdat_q;
        if (fetch_rd) begin
            mem_addr = msg_base + ADDR_W'(g_fetch);
        end else if (state == S_WRITE) begin
            mem_we         = 1'b1;
            mem_addr       = out_base + ADDR_W'(cnt);
            mem_write_data = hv[cnt[2:0]];
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            S_IDLE: begin
                cnt_nxt = 7'd0;
                if (start_ok)
                    state_nxt = S_LOAD;
            end
            S_LOAD: begin
                if (cnt == 7'd16) begin
                    state_nxt = S_COMPUTE;
                    cnt_nxt   = 7'd0;
                end else begin
                    cnt_nxt = cnt + 7'd1;
                end
            end
            S_COMPUTE: begin
                if (cnt == 7'd63) begin
                    state_nxt = S_UPDATE;
                    cnt_nxt   = 7'd0;
                end else begin
                    cnt_nxt = cnt + 7'd1;
                end
            end
            S_UPDATE: begin
                cnt_nxt   = 7'd0;
                state_nxt = last_blk ? S_WRITE : S_LOAD;
            end
            S_WRITE: begin
                if (cnt == 7'd7) begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = 7'd0;
                end else begin
                    cnt_nxt = cnt + 7'd1;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = 7'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            cnt      <= 7'd0;
            blk      <= '0;
            n_q      <= '0;
            msg_base <= '0;
            out_base <= '0;
            addr_q   <= '0;
            wdat_q   <= 32'h0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            addr_q <= mem_addr;
            wdat_q <= mem_write_data;
            if (start_ok) begin
                n_q      <= message_words;
                msg_base <= message_addr;
                out_base <= output_addr;
                blk      <= '0;
            end else if (state == S_UPDATE) begin
                blk <= blk + BLK_W'(1);
            end
        end
    end

    // Round logic; W[t+16] is formed from the window while W[t] is consumed.
    assign t1    = h + bsig1(e) + ((e & f) ^ (~e & g)) + K_TAB[cnt[5:0]] + w[0];
    assign t2    = bsig0(a) + ((a & b) ^ (a & c) ^ (b & c));
    assign w_new = w[0] + ssig0(w[1]) + w[9] + ssig1(w[14]);

    always_ff @(posedge clk) begin
        if (start_ok) begin
            for (int i = 0; i < 8; i++)
                hv[i] <= IV_TAB[i];
        end
        case (state)
            S_LOAD: begin
                if (cnt != 7'd0) begin
                    for (int i = 0; i < 15; i++)
                        w[i] <= w[i+1];
                    w[15] <= cap_word;
                end
                if (cnt == 7'd16) begin
                    a <= hv[0]; b <= hv[1]; c <= hv[2]; d <= hv[3];
                    e <= hv[4]; f <= hv[5]; g <= hv[6]; h <= hv[7];
                end
            end
            S_COMPUTE: begin
                for (int i = 0; i < 15; i++)
                    w[i] <= w[i+1];
                w[15] <= w_new;
                h <= g;
                g <= f;
                f <= e;
                e <= d + t1;
                d <= c;
                c <= b;
                b <= a;
                a <= t1 + t2;
            end
            S_UPDATE: begin
                hv[0] <= hv[0] + a; hv[1] <= hv[1] + b;
                hv[2] <= hv[2] + c; hv[3] <= hv[3] + d;
                hv[4] <= hv[4] + e; hv[5] <= hv[5] + f;
                hv[6] <= hv[6] + g; hv[7] <= hv[7] + h;
            end
            default: ;
        endcase
    end

`ifdef SHA256_CYCLE_CNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            cycle_count <= 32'h0;
        else if (start_ok)
            cycle_count <= 32'h0;
        else if (state != S_IDLE)
            cycle_count <= cycle_count + 32'h1;
    end
`endif

endmodule
